// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind uart_rx: edge-detected capture, first-word-fall-through output, sticky drop flag.
// Define UART_RX_FIFO_DROP_COUNT_EN to build the saturating drop_count; otherwise drop_count reads 0.
module uart_rx_fifo #(
  parameter int DATA_SIZE = 8,
  parameter int DEPTH     = 8,
  parameter int CW        = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic                 in_completed,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW-1:0]        count,
  output logic                 full,
  output logic                 overflow,
  input  logic                 clr_overflow,
  output logic [7:0]           drop_count
);

  localparam int             AW      = $clog2(DEPTH);
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  localparam logic [AW-1:0]  PTR_ONE = AW'(1);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);

  logic                 prev_c_q;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic [DATA_SIZE-1:0] mem_q [DEPTH];

  logic push, pop, wr_en, drop, full_w;

  assign full_w = (count_q == DEPTH_C);
  assign push   = in_completed & ~prev_c_q;
  assign pop    = (count_q != '0) & out_ready;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign wr_en  = push & (~full_w | pop);
  assign drop   = push & full_w & ~pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)   rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (drop)              overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;
  end

  // prev_c resets high so a level already present at release is not a push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_c_q   <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      prev_c_q   <= in_completed;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_data;
  end

`ifdef UART_RX_FIFO_DROP_COUNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // A drop coinciding with a clear restarts the count at one.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      if (clr_overflow)             drop_cnt_d = 8'd1;
      else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (clr_overflow) begin
      drop_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= 8'd0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = 8'd0;
`endif

  assign out_data  = mem_q[rd_ptr_q];
  assign out_valid = (count_q != '0);
  assign count     = count_q;
  assign full      = full_w;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized bench for uart_rx_fifo against a queue-based reference model (DATA_SIZE=5, DEPTH=4).
module tb_uart_rx_fifo;

  localparam int DATA_SIZE = 5;
  localparam int DEPTH     = 4;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [DATA_SIZE-1:0] in_data = '0;
  logic                 in_completed = 1'b0;
  logic [DATA_SIZE-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [CW-1:0]        count;
  logic                 full;
  logic                 overflow;
  logic                 clr_overflow = 1'b0;
  logic [7:0]           drop_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_SIZE-1:0] m_q[$];
  bit                   m_prev;
  bit                   m_ovf;
  int                   m_drops;
  logic                 rst_next = 1'b0;

  uart_rx_fifo #(.DATA_SIZE(DATA_SIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_completed(in_completed),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .full(full), .overflow(overflow),
    .clr_overflow(clr_overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_prev  = 1'b1;
    m_ovf   = 1'b0;
    m_drops = 0;
  endfunction

  function automatic void model_step();
    bit push, pop, dropped;
    int sz;
    if (!rst_n) return;
    push    = in_completed && !m_prev;
    sz      = m_q.size();
    pop     = (sz != 0) && out_ready;
    dropped = 1'b0;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (sz < DEPTH || pop) m_q.push_back(in_data);
      else dropped = 1'b1;
    end
    if (clr_overflow) begin
      m_ovf   = dropped;
      m_drops = dropped ? 1 : 0;
    end else if (dropped) begin
      m_ovf = 1'b1;
      if (m_drops < 255) m_drops++;
    end
    m_prev = in_completed;
  endfunction

  task automatic compare_all();
    int exp_drops;
`ifdef UART_RX_FIFO_DROP_COUNT_EN
    exp_drops = m_drops;
`else
    exp_drops = 0;
`endif
    check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) check("out_data", 32'(out_data), 32'(m_q[0]));
    check("count", 32'(count), 32'(m_q.size()));
    check("full", 32'(full), 32'(m_q.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("drop_count", 32'(drop_count), 32'(exp_drops));
  endtask

  // Compare at the falling edge, then drive the next inputs; the model advances at the rising edge.
  task automatic cycle(input logic ic, input logic [DATA_SIZE-1:0] d,
                       input logic rdy, input logic clr);
    @(negedge clk);
    compare_all();
    in_completed = ic;
    in_data      = d;
    out_ready    = rdy;
    clr_overflow = clr;
    rst_n        = rst_next;
    if (!rst_n) model_reset();
    @(posedge clk);
    model_step();
  endtask

  task automatic push_word(input logic [DATA_SIZE-1:0] d, input logic rdy);
    cycle(1'b0, d, 1'b0, 1'b0);
    cycle(1'b1, d, rdy, 1'b0);
  endtask

  initial begin
    logic ic_cur;
    int   p_tog, p_rdy, p_clr;
    model_reset();
    rst_next = 1'b0;
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b0);
    rst_next = 1'b1;

    // Single word, then completion held high: one push only.
    cycle(1'b0, 5'h0D, 1'b0, 1'b0);
    repeat (8) cycle(1'b1, 5'h0D, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, 5'h00, 1'b1, 1'b0);

    // Fill, drain in order.
    for (int i = 1; i <= 4; i++) push_word(DATA_SIZE'(i), 1'b0);
    repeat (5) cycle(1'b0, '0, 1'b1, 1'b0);

    // Fill, overflow on 5'h1F, clear.
    for (int i = 1; i <= 4; i++) push_word(DATA_SIZE'(i), 1'b0);
    push_word(5'h1F, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);

    // Full with simultaneous push and pop: no drop.
    push_word(5'h0A, 1'b1);
    repeat (5) cycle(1'b0, '0, 1'b1, 1'b0);

    // Drop counter saturation, then a drop coinciding with a clear.
    for (int i = 1; i <= 4; i++) push_word(DATA_SIZE'(i + 4), 1'b0);
    for (int i = 0; i < 260; i++) push_word(DATA_SIZE'($urandom), 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 5'h11, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    repeat (5) cycle(1'b0, '0, 1'b1, 1'b0);

    // Reset mid-stream with completion high; no push until it falls and rises again.
    for (int i = 0; i < 3; i++) push_word(DATA_SIZE'(20 + i), 1'b0);
    cycle(1'b1, 5'h15, 1'b0, 1'b0);
    rst_next = 1'b0;
    repeat (3) cycle(1'b1, 5'h15, 1'b0, 1'b0);
    rst_next = 1'b1;
    repeat (5) cycle(1'b1, 5'h15, 1'b0, 1'b0);
    cycle(1'b0, 5'h16, 1'b0, 1'b0);
    cycle(1'b1, 5'h16, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);

    // Randomized phases with varying push/pop pressure.
    ic_cur = 1'b0;
    for (int ph = 0; ph < 8; ph++) begin
      p_tog = 20 + 10 * (ph % 4);
      p_rdy = (ph % 3 == 0) ? 10 : ((ph % 3 == 1) ? 50 : 90);
      p_clr = 3;
      for (int c = 0; c < 150; c++) begin
        if ($urandom_range(99) < p_tog) ic_cur = ~ic_cur;
        cycle(ic_cur, DATA_SIZE'($urandom), $urandom_range(99) < p_rdy,
              $urandom_range(99) < p_clr);
      end
      if (ph == 5) begin
        rst_next = 1'b0;
        cycle(ic_cur, '0, 1'b0, 1'b0);
        rst_next = 1'b1;
      end
    end
    repeat (6) cycle(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    compare_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
